// File: rtl/clint_timer.sv
// Core-local interruptor: mtime/mtimecmp registers behind a single-entry LSU
// request/response port, with a registered timer interrupt to the CSR unit.
module clint_timer #(
  parameter int          ADDR_W   = 64,
  parameter int          DATA_W   = 64,
  parameter logic [63:0] BASE     = 64'h0200_0000,
  parameter int          TICK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  addr_hit,
  output logic                  clint_mtip
);

  localparam logic [ADDR_W-1:0] BASE_A   = BASE[ADDR_W-1:0];
  localparam logic [7:0]        PRE_LAST = 8'(TICK_DIV - 1);

  logic [DATA_W-1:0] mtime_q, mtime_d;
  logic [DATA_W-1:0] mtimecmp_q, mtimecmp_d;
  logic [7:0]        presc_q, presc_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              mtip_q, mtip_d;

  logic [ADDR_W-1:0] off;
  logic [15:0]       word_off;
  logic              sel_cmp, sel_time, accept, tick;
  logic [DATA_W-1:0] wmask, cmp_merged, time_merged;

  // Expand byte strobes into a bit mask for read-modify-write merging.
  for (genvar gi = 0; gi < DATA_W/8; gi++) begin : g_wmask
    assign wmask[gi*8 +: 8] = {8{req_wstrb[gi]}};
  end

  assign off         = req_addr - BASE_A;
  assign addr_hit    = (req_addr >= BASE_A) && (off[ADDR_W-1:16] == '0);
  assign word_off    = off[15:0] & 16'hFFF8;
  assign sel_cmp     = addr_hit && (word_off == 16'h4000);
  assign sel_time    = addr_hit && (word_off == 16'hBFF8);
  assign req_ready   = ~resp_valid_q | resp_ready;
  assign accept      = req_valid & req_ready;
  assign tick        = (presc_q == PRE_LAST);
  assign cmp_merged  = (mtimecmp_q & ~wmask) | (req_wdata & wmask);
  assign time_merged = (mtime_q & ~wmask) | (req_wdata & wmask);

  always_comb begin
    presc_d      = tick ? 8'd0 : presc_q + 8'd1;
    mtime_d      = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d   = mtimecmp_q;
    resp_valid_d = resp_valid_q & ~resp_ready;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_err_d   = ~(sel_cmp | sel_time);
      resp_rdata_d = '0;
      if (!req_write) begin
        if (sel_cmp)       resp_rdata_d = mtimecmp_q;
        else if (sel_time) resp_rdata_d = mtime_q;
      end else if (sel_cmp) begin
        mtimecmp_d = cmp_merged;
      end else if (sel_time) begin
        // A store to mtime overrides the tick increment on the same edge.
        mtime_d = time_merged;
      end
    end
    mtip_d = (mtime_d >= mtimecmp_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mtime_q      <= '0;
      mtimecmp_q   <= '1;
      presc_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mtip_q       <= 1'b0;
    end else begin
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      presc_q      <= presc_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mtip_q       <= mtip_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign clint_mtip = mtip_q;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: cycle model of the register map and handshake checked
// every cycle, plus directed literal checks; a second instance runs TICK_DIV=4.
module tb_clint_timer;

  localparam logic [63:0] BASE = 64'h0200_0000;
  localparam logic [63:0] A_CMP = BASE + 64'h4000;
  localparam logic [63:0] A_TIME = BASE + 64'hBFF8;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err, addr_hit, clint_mtip;
  logic [63:0] req_addr, req_wdata, resp_rdata;
  logic [7:0] req_wstrb;

  logic req4_valid, req4_ready, resp4_valid, resp4_err, addr4_hit, mtip4;
  logic [63:0] resp4_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clint_timer #(.ADDR_W(64), .DATA_W(64), .BASE(BASE), .TICK_DIV(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .addr_hit(addr_hit),
    .clint_mtip(clint_mtip)
  );

  clint_timer #(.ADDR_W(64), .DATA_W(64), .BASE(BASE), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req4_valid), .req_ready(req4_ready),
    .req_write(1'b0), .req_addr(A_TIME), .req_wdata(64'd0),
    .req_wstrb(8'd0), .resp_valid(resp4_valid), .resp_ready(1'b1),
    .resp_rdata(resp4_rdata), .resp_err(resp4_err), .addr_hit(addr4_hit),
    .clint_mtip(mtip4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the TICK_DIV=1 instance, advanced at every clock edge.
  logic [63:0] m_time, m_cmp, m_rd;
  logic        m_rv, m_err, m_mtip, started = 1'b0;

  always @(posedge clk) begin
    logic [63:0] off, nt, nc, val;
    logic hit, is_cmp, is_time, acc;
    started = 1'b1;
    if (!rst) begin
      m_time = 0; m_cmp = '1; m_rv = 0; m_rd = 0; m_err = 0; m_mtip = 0;
    end else begin
      acc = req_valid && (!m_rv || resp_ready);
      hit = (req_addr >= BASE) && (req_addr < BASE + 64'h10000);
      off = (req_addr - BASE) & ~64'h7;
      is_cmp = hit && (off == 64'h4000);
      is_time = hit && (off == 64'hBFF8);
      nt = m_time + 64'd1;
      nc = m_cmp;
      if (acc) begin
        m_err = !(is_cmp || is_time);
        m_rd = 0;
        if (!req_write) begin
          if (is_cmp) m_rd = m_cmp;
          if (is_time) m_rd = m_time;
        end else if (is_cmp || is_time) begin
          val = is_cmp ? m_cmp : m_time;
          for (int i = 0; i < 8; i++)
            if (req_wstrb[i]) val[8*i +: 8] = req_wdata[8*i +: 8];
          if (is_cmp) nc = val; else nt = val;
        end
        m_rv = 1;
      end else if (resp_ready) begin
        m_rv = 0;
      end
      m_time = nt;
      m_cmp = nc;
      m_mtip = (nt >= nc);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("mtip", {63'd0, clint_mtip}, {63'd0, m_mtip});
      chk("resp_valid", {63'd0, resp_valid}, {63'd0, m_rv});
      chk("req_ready", {63'd0, req_ready}, {63'd0, (!m_rv || resp_ready)});
      if (m_rv) begin
        chk("resp_rdata", resp_rdata, m_rd);
        chk("resp_err", {63'd0, resp_err}, {63'd0, m_err});
      end
    end
  end

  // Issue one access starting just after a clock edge; returns just after the accept edge.
  task automatic access(input logic w, input logic [63:0] a, input logic [63:0] wd,
                        input logic [7:0] ws, output logic [63:0] rd, output logic er);
    bit ok = 0;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = wd; req_wstrb = ws;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk); #1; ok = 1;
      end
    end
    req_valid = 0;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    rd = resp_rdata; er = resp_err;
    $display("access w=%0b addr=%h wdata=%h wstrb=%h -> rdata=%h err=%0b", w, a, wd, ws, rd, er);
  endtask

  task automatic load4(output logic [63:0] rd);
    req4_valid = 1;
    @(posedge clk); #1;
    req4_valid = 0;
    rd = resp4_rdata;
    $display("tick4 load -> rdata=%h", rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] rd, r4a, r4b;
    logic er;
    rst = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    resp_ready = 1; req4_valid = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    repeat (10) @(posedge clk);
    #1;
    access(0, A_TIME, 0, 0, rd, er);
    chk("mtime_after_idle", rd, 64'd10);
    chk("mtip_idle", {63'd0, clint_mtip}, 64'd0);

    access(1, A_CMP, 64'd20, 8'hFF, rd, er);
    repeat (12) @(posedge clk);
    #1;
    chk("mtip_set", {63'd0, clint_mtip}, 64'd1);
    access(1, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er);
    chk("mtip_cleared", {63'd0, clint_mtip}, 64'd0);

    access(1, A_CMP, 64'd5, 8'hFF, rd, er);
    access(1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er);
    access(0, A_TIME, 0, 0, rd, er);
    chk("mtime_store_wins", rd, 64'hFFFF_FFFF_FFFF_FFFE);
    access(0, A_TIME, 0, 0, rd, er);
    chk("mtime_pre_wrap", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    access(0, A_TIME, 0, 0, rd, er);
    chk("mtime_wrapped", rd, 64'd0);
    chk("mtip_after_wrap", {63'd0, clint_mtip}, 64'd0);

    access(1, A_CMP, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, rd, er);
    access(1, A_CMP, 64'h1111_2222_3333_4444, 8'h0F, rd, er);
    access(0, A_CMP, 0, 0, rd, er);
    chk("partial_store", rd, 64'hAAAA_BBBB_3333_4444);

    @(posedge clk); #1;
    resp_ready = 0;
    access(0, A_TIME, 0, 0, rd, er);
    req_valid = 1; req_write = 0; req_addr = A_CMP;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_req_ready", {63'd0, req_ready}, 64'd0);
      chk("hold_resp_valid", {63'd0, resp_valid}, 64'd1);
    end
    @(posedge clk); #1;
    resp_ready = 1;
    @(posedge clk); #1;
    req_valid = 0;
    chk("second_load_data", resp_rdata, 64'hAAAA_BBBB_3333_4444);
    $display("held response released, second load rdata=%h", resp_rdata);

    req_addr = BASE + 64'h10000; #1;
    chk("addr_hit_above", {63'd0, addr_hit}, 64'd0);
    req_addr = BASE - 64'd8; #1;
    chk("addr_hit_below", {63'd0, addr_hit}, 64'd0);
    req_addr = BASE + 64'h8000; #1;
    chk("addr_hit_inside", {63'd0, addr_hit}, 64'd1);
    access(0, BASE + 64'h8000, 0, 0, rd, er);
    chk("unmapped_rdata", rd, 64'd0);
    chk("unmapped_err", {63'd0, er}, 64'd1);
    access(1, BASE + 64'h8000, 64'd7, 8'hFF, rd, er);
    chk("unmapped_wr_err", {63'd0, er}, 64'd1);

    load4(r4a);
    repeat (39) @(posedge clk);
    #1;
    load4(r4b);
    chk("tick4_rate", r4b - r4a, 64'd10);
    chk("tick4_err", {63'd0, resp4_err}, 64'd0);
    chk("tick4_ready", {63'd0, req4_ready}, 64'd1);
    chk("tick4_hit", {63'd0, addr4_hit}, 64'd1);
    chk("tick4_mtip", {63'd0, mtip4}, 64'd0);
    chk("tick4_valid", {63'd0, resp4_valid}, 64'd1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
